// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
// Shared definitions for the sequential ALU: operation encodings, the
// control FSM state type and the value driven for illegal operations.
// Imported by seq_alu and seq_alu_mul.
// -----------------------------------------------------------------------------
package seq_alu_pkg;

    // Operation codes. Codes 9..15 are illegal. Code 8 (MUL) is illegal
    // too when the multiplier is not compiled in.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_XOR  = 4'd1,
        OP_AND  = 4'd2,
        OP_RSL  = 4'd3,
        OP_MOV  = 4'd4,
        OP_LD   = 4'd5,
        OP_ST   = 4'd6,
        OP_BLQZ = 4'd7,
        OP_MUL  = 4'd8
    } alu_op_t;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } seq_alu_state_t;

    // Result value presented for an illegal operation (zero flag follows).
    localparam int unsigned ALU_ILLEGAL_RESULT = 0;

endpackage : seq_alu_pkg

// File: rtl/seq_alu_mul.sv
// -----------------------------------------------------------------------------
// seq_alu_mul
// Iterative shift-add multiplier, one multiplier bit per clock.
// A one-cycle 'start' pulse captures a and b. WIDTH step cycles follow;
// 'done' is high during the last step, and 'product' then carries the
// complete 2*WIDTH-bit product so the caller can register it on that edge.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       capture operands and begin (ignored while busy)
//   a, b        WIDTH-bit unsigned operands
//   done        final step in progress; product is valid this cycle
//   product     2*WIDTH-bit product (meaningful only while done is high)
// -----------------------------------------------------------------------------
module seq_alu_mul
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic [2*WIDTH-1:0] step_sum;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;

        // Add the shifted multiplicand when the current multiplier LSB is set.
        step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
        product  = step_sum;

        if (start && !busy_q) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    // NOTE: the datapath registers are reset along with the control bits.
    // They are few, and a known value keeps an aborted multiply from
    // leaving stale partial sums behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples its
            // pre-edge value regardless of statement order.
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule : seq_alu_mul

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Handshaked ALU between register-file read and writeback. Each accepted
// operation is executed and its result, carry, zero and branch flag are
// registered behind a valid/ready output stage. A stalled consumer holds
// the result stable and backpressures issue through in_ready.
//
// Optional feature: define SEQ_ALU_MUL_EN to compile in the iterative
// multiplier (op 8, latency WIDTH+1). Without it, op 8 is illegal.
//
// Parameters:
//   WIDTH      operand/result width, power of two, >= 4
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operation handshake (accept = in_valid && in_ready)
//   op, a, b            operation code and operands, captured at accept
//   out_valid/out_ready result handshake
//   result              registered result
//   carry               ADD carry-out / MUL high-half nonzero, else 0
//   zero                result == 0
//   jump_flag           BLQZ taken (signed a <= 0)
// -----------------------------------------------------------------------------
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             jump_flag
);

    localparam int SHW = $clog2(WIDTH);

    seq_alu_state_t   state_q,  state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;
    logic             zero_q,   zero_d;
    logic             jump_q,   jump_d;

    alu_op_t          op_e;
    logic             accept;
    logic             is_mul;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_jump;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] rot;
    logic [SHW-1:0]   sh;
    logic [SHW-1:0]   src_idx;

    assign op_e = alu_op_t'(op);

    // -------------------------------------------------------------------------
    // Single-cycle operation decode
    // -------------------------------------------------------------------------
    always_comb begin
        alu_result = WIDTH'(ALU_ILLEGAL_RESULT);
        alu_carry  = 1'b0;
        alu_jump   = 1'b0;
        sum        = {1'b0, a} + {1'b0, b};

        // Rotate left by b mod WIDTH: result[i] = a[(i - sh) mod WIDTH].
        // The SHW-bit index subtraction wraps modulo WIDTH for free.
        sh      = b[SHW-1:0];
        src_idx = '0;
        rot     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            src_idx = SHW'(i) - sh;
            rot[i]  = a[src_idx];
        end

        case (op_e)
            OP_ADD: begin
                alu_result = sum[WIDTH-1:0];
                alu_carry  = sum[WIDTH];
            end
            OP_XOR:        alu_result = a ^ b;
            OP_AND:        alu_result = a & b;
            OP_RSL:        alu_result = rot;
            OP_MOV, OP_LD: alu_result = b;
            OP_ST:         alu_result = a;
            OP_BLQZ: begin
                alu_result = '0;
                alu_jump   = (a == '0) || a[WIDTH-1];
            end
            default: ;  // illegal (and MUL, which takes the multi-cycle path)
        endcase
    end

    // -------------------------------------------------------------------------
    // Optional multiplier
    // -------------------------------------------------------------------------
`ifdef SEQ_ALU_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign is_mul = (op_e == OP_MUL);

    seq_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Control FSM: next state and result-register loads
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        accept   = in_valid && in_ready;

        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        jump_d   = jump_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = ST_MUL;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_result;
                        carry_d  = alu_carry;
                        zero_d   = (alu_result == '0);
                        jump_d   = alu_jump;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_product[WIDTH-1:0];
                    carry_d  = |mul_product[2*WIDTH-1:WIDTH];
                    zero_d   = (mul_product[WIDTH-1:0] == '0);
                    jump_d   = 1'b0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            jump_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            jump_q   <= jump_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign jump_flag = jump_q;

endmodule : seq_alu
